// File: rtl/video_tile_renderer.sv
// video_tile_renderer
// Character-cell renderer sitting behind the sync generator. Each beam
// position becomes a tile-map lookup, then a glyph-row lookup, then a pixel
// colour. It produces one pixel per clock with a fixed 5-clock latency. The
// hsync/vsync strobes travel through a matching 5-stage delay so they stay
// aligned with the colour outputs.
//
// Pipeline (input sampled by the edge that ends cycle t):
//   t+1 : map address registered
//   t+2 : tile entry returned by the tile-map RAM
//   t+3 : pattern address and tile attributes (plus blink phase) registered
//   t+4 : glyph row returned by the pattern ROM
//   t+5 : pixel colour and delayed syncs registered
module video_tile_renderer #(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 60,
    parameter logic [8:0] FG_RGB    = 9'b111_111_111,
    parameter logic [8:0] BG_RGB    = 9'b000_000_001,
    parameter int         BLINK_BIT = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [9:0]  i_hpos,
    input  logic [9:0]  i_vpos,
    input  logic        i_visible,
    input  logic        i_hsync,
    input  logic        i_vsync,
    output logic [12:0] o_map_addr,
    input  logic [7:0]  i_map_data,
    output logic [8:0]  o_pat_addr,
    input  logic [7:0]  i_pat_data,
    output logic [2:0]  o_red,
    output logic [2:0]  o_grn,
    output logic [2:0]  o_blu,
    output logic        o_hsync,
    output logic        o_vsync
);

    // Grid limits as narrow constants so the range compare stays 8 bits wide.
    localparam logic [7:0] COLS_LIM = COLS[7:0];
    localparam logic [7:0] ROWS_LIM = ROWS[7:0];

    // ------------------------------------------------------------------
    // Stage 1 address arithmetic
    // ------------------------------------------------------------------
    logic [6:0]  tile_col;
    logic [6:0]  tile_row;
    logic        in_grid;
    logic [12:0] tile_addr;

    // The tile index is row*80 + col, built from two shifts and adds so no
    // multiplier is inferred. The 640x480 area tops out at 59*80+79 = 4799.
    // The grid test is redundant for a well-behaved sync generator. It keeps
    // an out-of-range beam from producing a stray address.
    always_comb begin
        tile_col  = i_hpos[9:3];
        tile_row  = i_vpos[9:3];
        in_grid   = ({1'b0, tile_col} < COLS_LIM) && ({1'b0, tile_row} < ROWS_LIM);
        tile_addr = {tile_row, 6'b0}
                  + {2'b0, tile_row, 4'b0}
                  + {6'b0, tile_col};
    end

    // ------------------------------------------------------------------
    // Delay lines for beam sub-position, visibility and sync strobes
    // ------------------------------------------------------------------
    // hpos[2:0] is needed at the pixel-select stage (4 registers).
    // vpos[2:0] is needed at the pattern-address stage (2 registers).
    // visible gates the colour register (4 registers plus the colour register).
    // The syncs come straight out of the 5th register.
    logic [11:0] hpos_pipe;
    logic [5:0]  vpos_pipe;
    logic [3:0]  vis_pipe;
    logic [4:0]  hsync_pipe;
    logic [4:0]  vsync_pipe;

    // Stage 1: register the tile-map address, forced to 0 while blanking.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_map_addr <= '0;
        end else if (i_visible && in_grid) begin
            o_map_addr <= tile_addr;
        end else begin
            o_map_addr <= '0;
        end
    end

    // Shift every side-band delay line by one stage per pixel clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hpos_pipe  <= '0;
            vpos_pipe  <= '0;
            vis_pipe   <= '0;
            hsync_pipe <= '0;
            vsync_pipe <= '0;
        end else begin
            hpos_pipe  <= {hpos_pipe[8:0], i_hpos[2:0]};
            vpos_pipe  <= {vpos_pipe[2:0], i_vpos[2:0]};
            vis_pipe   <= {vis_pipe[2:0], i_visible};
            hsync_pipe <= {hsync_pipe[3:0], i_hsync};
            vsync_pipe <= {vsync_pipe[3:0], i_vsync};
        end
    end

    // ------------------------------------------------------------------
    // Frame counter driving the blink phase
    // ------------------------------------------------------------------
    logic [5:0] frame_cnt;
    logic       vsync_prev;

    // Count rising edges of the incoming vsync. The edge register resets to 0,
    // so a vsync already high at reset release counts as the first edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt  <= '0;
            vsync_prev <= 1'b0;
        end else begin
            vsync_prev <= i_vsync;
            if (i_vsync && !vsync_prev) begin
                frame_cnt <= frame_cnt + 6'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: pattern address and tile attributes
    // ------------------------------------------------------------------
    logic blink_s3;
    logic inverse_s3;
    logic phase_s3;

    // Latch the glyph address and attributes together with the blink phase.
    // Sampling the phase here keeps a whole pixel on one phase. A vsync edge
    // on the same clock lands in frame_cnt only after this capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pat_addr <= '0;
            blink_s3   <= 1'b0;
            inverse_s3 <= 1'b0;
            phase_s3   <= 1'b0;
        end else begin
            o_pat_addr <= {i_map_data[5:0], vpos_pipe[5:3]};
            blink_s3   <= i_map_data[7];
            inverse_s3 <= i_map_data[6];
            phase_s3   <= frame_cnt[BLINK_BIT];
        end
    end

    // ------------------------------------------------------------------
    // Stage 4: hold attributes while the pattern ROM answers
    // ------------------------------------------------------------------
    logic blink_s4;
    logic inverse_s4;
    logic phase_s4;

    // Carry the attributes one more clock so they meet their glyph row.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_s4   <= 1'b0;
            inverse_s4 <= 1'b0;
            phase_s4   <= 1'b0;
        end else begin
            blink_s4   <= blink_s3;
            inverse_s4 <= inverse_s3;
            phase_s4   <= phase_s3;
        end
    end

    // ------------------------------------------------------------------
    // Stage 5: pixel select and colour
    // ------------------------------------------------------------------
    logic [2:0] pix_sel;
    logic       pix_bit;
    logic       pix_on;
    logic [8:0] pix_colour;

    // Pick the glyph bit (bit 7 is leftmost), suppress it in the blink-off
    // phase, apply inverse, and map the result to foreground/background.
    always_comb begin
        pix_sel    = 3'd7 - hpos_pipe[11:9];
        pix_bit    = i_pat_data[pix_sel];
        pix_on     = (pix_bit & ~(blink_s4 & phase_s4)) ^ inverse_s4;
        pix_colour = pix_on ? FG_RGB : BG_RGB;
    end

    logic [8:0] rgb_q;

    // Register the final colour. Blanking always forces black.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rgb_q <= '0;
        end else if (vis_pipe[3]) begin
            rgb_q <= pix_colour;
        end else begin
            rgb_q <= '0;
        end
    end

    // Outputs are taken straight from registers.
    assign o_red   = rgb_q[8:6];
    assign o_grn   = rgb_q[5:3];
    assign o_blu   = rgb_q[2:0];
    assign o_hsync = hsync_pipe[4];
    assign o_vsync = vsync_pipe[4];

endmodule
